lsu_ctrl: RTL



---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_extend.sv | 31 +++
 rtl/lsu_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage.
//   - mem_mask one-hot size encodings (MASK_D/W/H/B)
//   - RV64 load/store funct3 encodings
//   - lsu_ctrl FSM state type
//   - small decode helpers: size mask, natural-alignment low-bit mask, legality
package lsu_pkg;

  localparam logic [3:0] MASK_D = 4'b0001;
  localparam logic [3:0] MASK_W = 4'b0010;
  localparam logic [3:0] MASK_H = 4'b0100;
  localparam logic [3:0] MASK_B = 4'b1000;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  // funct3[1:0] -> one-hot mem_mask
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      default: return MASK_D;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Unsigned variants exist only for loads; 111 is never legal.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    return (f3 != F3_ILL) && !(store && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational size/sign extension of right-justified load data.
//   funct3_i : load funct3 (bit 2 = unsigned, bits 1:0 = size)
//   rdata_i  : raw data from mem, right-justified
//   ext_o    : data sign- or zero-extended from bit 7/15/31, doubles unchanged
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ext_o
);

  logic sgn_b, sgn_h, sgn_w;

  assign sgn_b = ~funct3_i[2] & rdata_i[7];
  assign sgn_h = ~funct3_i[2] & rdata_i[15];
  assign sgn_w = ~funct3_i[2] & rdata_i[31];

  always_comb begin
    ext_o = rdata_i;
    case (funct3_i[1:0])
      2'd0:    ext_o = {{(XLEN-8){sgn_b}},  rdata_i[7:0]};
      2'd1:    ext_o = {{(XLEN-16){sgn_h}}, rdata_i[15:0]};
      2'd2:    ext_o = {{(XLEN-32){sgn_w}}, rdata_i[31:0]};
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage between execute and the data memory.
// Accepts one request, issues a single-cycle access to mem, waits out the
// registered read latency for loads, and returns one response.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_*                : request handshake and payload from execute
//   mem_*                : access port to the data memory
//   resp_*               : response handshake, extended load data, error flag
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   -> misaligned requests return resp_err without touching mem
//   undefined -> low address bits are cleared to natural alignment instead
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_ena,
  output logic            mem_wen,
  output logic [3:0]      mem_mask,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int CNT_W = 3;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        low_mask;
  logic              req_err;
  logic [XLEN-1:0]   req_addr_al;
  logic [XLEN-1:0]   ext_rdata;

  assign low_mask = align_mask(req_funct3[1:0]);

`ifdef LSU_MISALIGN_CHECK_EN
  logic req_misalign;
  assign req_misalign = |(req_addr[2:0] & low_mask);
  assign req_err      = !f3_legal(req_store, req_funct3) || req_misalign;
  assign req_addr_al  = req_addr;
`else
  assign req_err      = !f3_legal(req_store, req_funct3);
  assign req_addr_al  = {req_addr[XLEN-1:3], req_addr[2:0] & ~low_mask};
`endif

  lsu_extend #(
    .XLEN (XLEN)
  ) u_extend (
    .funct3_i (funct3_q),
    .rdata_i  (mem_rdata),
    .ext_o    (ext_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    mem_ena    = 1'b0;
    mem_wen    = 1'b0;
    mem_mask   = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr_al;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          // Errors skip mem entirely and answer straight away.
          state_d  = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_ena   = 1'b1;
        mem_wen   = store_q;
        mem_addr  = addr_q;
        mem_mask  = size_mask(funct3_q[1:0]);
        mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
        if (store_q) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = ext_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
